// File: rtl/prog_loader.sv
// Boot loader: holds the CPU halted, loads a byte-streamed program into RAM,
// verifies it by checksum and readback, then releases the core.
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          READ_LAT  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        RELOAD,
  output logic        HALT,
  output logic [15:0] ADDRESS,
  output logic        EXT_RAM_RW,
  output logic        EXT_RAM_EN,
  output logic [15:0] BUS_OUT,
  output logic        BUS_OE,
  input  logic [15:0] BUS_IN,
  output logic        DONE,
  output logic [1:0]  ERR,
  output logic [3:0]  dbg_state
);

  // Stream handshake: a byte moves on a rising edge where IN_VALID and
  // IN_READY are both high; the sender must hold IN_DATA until then.

  typedef enum logic [3:0] {
    S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CK_HI, S_CK_LO,
    S_CHECK1, S_RD, S_WAIT, S_CHECK2, S_RUN, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] ck_q, ck_d;
  logic [15:0] sum_w_q, sum_w_d;
  logic [15:0] sum_r_q, sum_r_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] bus_q, bus_d;
  logic [1:0]  err_q, err_d;
  logic [1:0]  lat_q, lat_d;
  logic        ready_q, ready_d;

  logic        take;
  logic        more;
  logic        sample;
  logic [15:0] idx_inc;

  assign take    = IN_VALID & ready_q;
  assign idx_inc = idx_q + 16'd1;
  // 17-bit compare so N = 16'hFFFF terminates correctly.
  assign more    = ({1'b0, idx_q} + 17'd1) < {1'b0, cnt_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    ck_d    = ck_q;
    sum_w_d = sum_w_q;
    sum_r_d = sum_r_q;
    addr_d  = addr_q;
    bus_d   = bus_q;
    err_d   = err_q;
    lat_d   = lat_q;
    sample  = 1'b0;

    case (state_q)
      S_HDR_HI: if (take) begin
        cnt_d[15:8] = IN_DATA;
        state_d     = S_HDR_LO;
      end
      S_HDR_LO: if (take) begin
        cnt_d[7:0] = IN_DATA;
        state_d    = ({cnt_q[15:8], IN_DATA} != 16'd0) ? S_DATA_HI : S_CK_HI;
      end
      S_DATA_HI: if (take) begin
        hi_d    = IN_DATA;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (take) begin
        bus_d   = {hi_q, IN_DATA};
        addr_d  = BASE_ADDR + idx_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        sum_w_d = sum_w_q + bus_q;
        idx_d   = idx_inc;
        state_d = more ? S_DATA_HI : S_CK_HI;
      end
      S_CK_HI: if (take) begin
        ck_d[15:8] = IN_DATA;
        state_d    = S_CK_LO;
      end
      S_CK_LO: if (take) begin
        ck_d[7:0] = IN_DATA;
        state_d   = S_CHECK1;
      end
      S_CHECK1: begin
        if (ck_q != sum_w_q) begin
          err_d   = 2'b01;
          state_d = S_FAIL;
        end else if (cnt_q == 16'd0) begin
          state_d = S_RUN;
        end else begin
          idx_d   = 16'd0;
          addr_d  = BASE_ADDR;
          lat_d   = 2'd0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (READ_LAT == 0) begin
          sample = 1'b1;
        end else begin
          lat_d   = 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (int'(lat_q) == READ_LAT - 1) sample = 1'b1;
        else lat_d = lat_q + 2'd1;
      end
      S_CHECK2: begin
        if (sum_r_q != sum_w_q) begin
          err_d   = 2'b10;
          state_d = S_FAIL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN, S_FAIL: if (RELOAD) begin
        err_d   = 2'b00;
        sum_w_d = 16'd0;
        sum_r_d = 16'd0;
        idx_d   = 16'd0;
        cnt_d   = 16'd0;
        state_d = S_HDR_HI;
      end
      default: state_d = S_FAIL;
    endcase

    // Readback sample point, shared by the zero- and nonzero-latency paths.
    if (sample) begin
      sum_r_d = sum_r_q + BUS_IN;
      idx_d   = idx_inc;
      if (more) begin
        addr_d  = BASE_ADDR + idx_inc;
        state_d = S_RD;
      end else begin
        state_d = S_CHECK2;
      end
    end
  end

  always_comb begin
    ready_d = 1'b0;
    case (state_d)
      S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO, S_CK_HI, S_CK_LO: ready_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  // IN_READY is registered so it reads 0 in the first cycle out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_HDR_HI;
      cnt_q   <= 16'd0;
      idx_q   <= 16'd0;
      hi_q    <= 8'd0;
      ck_q    <= 16'd0;
      sum_w_q <= 16'd0;
      sum_r_q <= 16'd0;
      addr_q  <= 16'd0;
      bus_q   <= 16'd0;
      err_q   <= 2'b00;
      lat_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      ck_q    <= ck_d;
      sum_w_q <= sum_w_d;
      sum_r_q <= sum_r_d;
      addr_q  <= addr_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
    end
  end

  assign IN_READY   = ready_q;
  assign HALT       = (state_q != S_RUN);
  assign DONE       = (state_q == S_RUN);
  assign ERR        = err_q;
  assign ADDRESS    = addr_q;
  assign BUS_OUT    = bus_q;
  assign EXT_RAM_EN = (state_q == S_WRITE) || (state_q == S_RD) || (state_q == S_WAIT);
  assign EXT_RAM_RW = (state_q == S_WRITE);
  assign BUS_OE     = (state_q == S_WRITE);
  assign dbg_state  = state_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the 16-bit bus CPU core.
- Holds the core halted, receives a program as a byte stream over a valid/ready handshake, and writes it as 16-bit words into RAM through the core's external RAM access path (HALT, ADDRESS, EXT_RAM_RW, EXT_RAM_EN, BUS).
- After writing, it reads every word back and checks it against checksums, then releases HALT on success.

Parameters:
- BASE_ADDR, 16'h0000, RAM address of the first loaded word.
- READ_LAT, 1, cycles from a read strobe (EN=1, RW=0) to valid data on BUS_IN. Legal range 0..3.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader accepts a byte; transfer occurs when IN_VALID & IN_READY at a rising edge.
- RELOAD  in  1  single-cycle request to start a new load.
- HALT  out  1  drives the core's HALT input.
- ADDRESS  out  16  RAM address while HALT=1.
- EXT_RAM_RW  out  1  1 = write BUS into RAM, 0 = RAM drives BUS.
- EXT_RAM_EN  out  1  RAM access strobe.
- BUS_OUT  out  16  write data; the integrator tristates it onto BUS.
- BUS_OE  out  1  BUS_OUT drive enable. High only during write cycles.
- BUS_IN  in  16  BUS sampled for readback.
- DONE  out  1  load finished and verified; core running.
- ERR  out  2  error code: 00 none, 01 stream checksum mismatch, 10 readback mismatch.

Behaviour:
- Reset values:
  - HALT=1; everything else 0: IN_READY, EXT_RAM_EN, EXT_RAM_RW, BUS_OE, DONE, ERR, ADDRESS, BUS_OUT.
  - State HDR_HI.
- Stream format, all 16-bit fields high byte first: count N (2 bytes), then N words (2N bytes), then a 16-bit checksum equal to the sum of the N words mod 2^16.
- States and transitions:
  - HDR_HI, HDR_LO: IN_READY=1; capture N.
  - After HDR_LO: go to DATA_HI if N≠0, else CK_HI.
  - DATA_HI, DATA_LO: IN_READY=1; assemble the word.
  - WRITE, exactly 1 cycle, IN_READY=0: EN=1, RW=1, BUS_OE=1, ADDRESS=BASE_ADDR+idx, BUS_OUT=word; sum_w += word; idx++.
  - After WRITE: go to DATA_HI if idx<N, else CK_HI.
  - CK_HI, CK_LO: IN_READY=1; capture the sender checksum.
  - CHECK1: if captured ≠ sum_w, go to FAIL with ERR=01. Else if N=0, go to RUN. Else idx=0 and go to RD.
  - RD, 1 cycle: EN=1, RW=0, BUS_OE=0, ADDRESS=BASE_ADDR+idx.
  - WAIT: hold ADDRESS, EN=1 and RW=0 for READ_LAT cycles after RD, then sample BUS_IN; sum_r += BUS_IN; idx++. With READ_LAT=0, BUS_IN is sampled in the RD cycle itself.
  - After the sample: go to RD if idx<N, else CHECK2.
  - CHECK2: if sum_r ≠ sum_w, go to FAIL with ERR=10; else go to RUN.
  - RUN: HALT=0, DONE=1, EN=0; ADDRESS and BUS_OUT hold their last values.
  - FAIL: HALT=1, DONE=0; ERR holds its value.
- Transfer timing: no byte is lost on IN_VALID stalls. Each state waits indefinitely for the handshake.
- ADDRESS arithmetic is mod 2^16, so BASE_ADDR+idx wraps past 16'hFFFF to 0. N is 16-bit; N=16'hFFFF is legal.
- sum_w and sum_r are 16-bit wrap-around adders, cleared on entry to HDR_HI.
- RELOAD:
  - Honoured only in RUN or FAIL.
  - In the next cycle: HALT=1, DONE=0, ERR=00, sums and idx cleared, go to HDR_HI.
  - Ignored in all other states.
- RST in any state, including mid-write or mid-verify: the next cycle has reset values. A partially written RAM is left as is.
- EN, RW and BUS_OE are always 0 when HALT=0.
- BUS_OE=1 only while RW=1.

Test Plan:
- N=2, words 16'h1234 and 16'hABCD, checksum 16'hBE01, BASE 0, READ_LAT 1, memory model correct:
  - Two write cycles at address 0 and 1 with the exact data.
  - Two reads follow.
  - HALT falls and DONE=1 with ERR=00.
- Same stream with checksum 16'hBE00 -> no read cycles, ERR=01, HALT stays 1, DONE=0.
- Memory model corrupts address 1 to 16'hABCC on readback -> ERR=10, HALT=1.
- N=0 with checksum 16'h0000 -> no RAM strobes, DONE=1 right after CHECK1. With checksum 16'h0001 -> ERR=01.
- BASE_ADDR=16'hFFFF, N=2 -> writes at 16'hFFFF then 16'h0000. Random IN_VALID gaps produce identical RAM contents.
- RST asserted during the second WRITE:
  - Outputs return to reset values next cycle.
  - Then RELOAD in RUN after a good load returns HALT=1, DONE=0 and accepts a fresh header.
